mem_stage: RTL and testbench

Memory stage of the 5-stage MIPS pipeline, directly downstream of the execute stage. It holds the E/M pipeline register and a word-organised data memory supporting byte, halfword and word loads and stores. It also holds the M/W pipeline register that feeds write-back. Store data can be late-forwarded from write-back, and misaligned or out-of-range accesses are flagged and suppressed.

---
 rtl/mem_stage.sv | 179 +++++++++++++++++
 tb/tb_mem_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage holding the E/M register, a word-organised
// data memory with byte/halfword/word access, and the M/W register.
// Misaligned and out-of-range accesses are flagged and have no effect.
module mem_stage #(
  parameter int          DM_WORDS = 1024,
  parameter logic [31:0] DM_BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] IR_E,
  input  logic [31:0] PC8_E,
  input  logic [31:0] ALUOUT_E,
  input  logic [31:0] RT_E,
  input  logic        Forward_RT_M,
  input  logic [31:0] mux_Wdata_out,
  output logic [31:0] IR_M,
  output logic [31:0] PC8_M,
  output logic [31:0] ALUOUT_M,
  output logic [31:0] RT_M,
  output logic [31:0] IR_W,
  output logic [31:0] PC8_W,
  output logic [31:0] ALUOUT_W,
  output logic [31:0] DM_W,
  output logic        adel_M,
  output logic        ades_M
);

  localparam int          AW       = $clog2(DM_WORDS);
  localparam logic [32:0] DM_BYTES = 33'(DM_WORDS) << 2;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  // Data memory; starts out zeroed and is deliberately untouched by reset.
  logic [31:0] mem [DM_WORDS] = '{default: 32'h0};

  logic [5:0]    op;
  logic          is_lw, is_lh, is_lhu, is_lb, is_lbu;
  logic          is_sw, is_sh, is_sb;
  logic          is_load, is_store;
  logic [31:0]   addr;
  logic [31:0]   off;
  logic          in_range;
  logic          misaligned;
  logic [AW-1:0] idx;
  logic [31:0]   wd;
  logic [31:0]   wlane;
  logic [3:0]    be;
  logic          we;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;

  assign op   = IR_M[31:26];
  assign addr = ALUOUT_M;

  // Decode the instruction sitting in M into access kind and width.
  always_comb begin
    is_lw    = (op == OP_LW);
    is_lh    = (op == OP_LH);
    is_lhu   = (op == OP_LHU);
    is_lb    = (op == OP_LB);
    is_lbu   = (op == OP_LBU);
    is_sw    = (op == OP_SW);
    is_sh    = (op == OP_SH);
    is_sb    = (op == OP_SB);
    is_load  = is_lw | is_lh | is_lhu | is_lb | is_lbu;
    is_store = is_sw | is_sh | is_sb;
  end

  // Address translation, range and alignment checks, and the error flags.
  always_comb begin
    off        = addr - DM_BASE;
    in_range   = ({1'b0, off} < DM_BYTES);
    idx        = off[AW+1:2];
    misaligned = ((is_lw | is_sw) & (addr[1:0] != 2'b00))
               | ((is_lh | is_lhu | is_sh) & addr[0]);
    adel_M     = is_load  & (misaligned | ~in_range);
    ades_M     = is_store & (misaligned | ~in_range);
  end

  // Store data is steered into every lane it could land in; byte enables
  // then pick which lanes actually change.
  always_comb begin
    wd    = Forward_RT_M ? mux_Wdata_out : RT_M;
    wlane = wd;
    be    = 4'b0000;
    if (is_sw) begin
      wlane = wd;
      be    = 4'b1111;
    end else if (is_sh) begin
      wlane = {wd[15:0], wd[15:0]};
      be    = addr[1] ? 4'b1100 : 4'b0011;
    end else if (is_sb) begin
      wlane = {4{wd[7:0]}};
      case (addr[1:0])
        2'b00:   be = 4'b0001;
        2'b01:   be = 4'b0010;
        2'b10:   be = 4'b0100;
        default: be = 4'b1000;
      endcase
    end
  end

  // A store only commits when the pipe advances, the address is good and
  // reset is not holding the stage.
  assign we = en & rst_n & is_store & ~ades_M;

  // Lane-masked write into the data memory.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
  end

  // Combinational read, so a load right behind a store sees the new word.
  assign rd_word = mem[idx];

  // Lane selection and sign/zero extension of load data.
  always_comb begin
    case (addr[1:0])
      2'b00:   rd_byte = rd_word[7:0];
      2'b01:   rd_byte = rd_word[15:8];
      2'b10:   rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half   = addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = 32'h0;
    if (!adel_M) begin
      if (is_lw) begin
        load_data = rd_word;
      end else if (is_lh) begin
        load_data = {{16{rd_half[15]}}, rd_half};
      end else if (is_lhu) begin
        load_data = {16'h0, rd_half};
      end else if (is_lb) begin
        load_data = {{24{rd_byte[7]}}, rd_byte};
      end else if (is_lbu) begin
        load_data = {24'h0, rd_byte};
      end
    end
  end

  // E/M and M/W pipeline registers, advancing together when en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IR_M     <= 32'h0;
      PC8_M    <= 32'h0;
      ALUOUT_M <= 32'h0;
      RT_M     <= 32'h0;
      IR_W     <= 32'h0;
      PC8_W    <= 32'h0;
      ALUOUT_W <= 32'h0;
      DM_W     <= 32'h0;
    end else if (en) begin
      IR_M     <= IR_E;
      PC8_M    <= PC8_E;
      ALUOUT_M <= ALUOUT_E;
      RT_M     <= RT_E;
      IR_W     <= IR_M;
      PC8_W    <= PC8_M;
      ALUOUT_W <= ALUOUT_M;
      DM_W     <= load_data;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scenario tasks drive mem_stage; a scoreboard queue holds what
// each instruction must look like when it reaches write-back.
module tb_mem_stage;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] IR_E, PC8_E, ALUOUT_E, RT_E;
  logic        Forward_RT_M;
  logic [31:0] mux_Wdata_out;
  logic [31:0] IR_M, PC8_M, ALUOUT_M, RT_M;
  logic [31:0] IR_W, PC8_W, ALUOUT_W, DM_W;
  logic        adel_M, ades_M;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc8;
    logic [31:0] alu;
    bit          chk;
    logic [31:0] dm;
  } sb_t;

  sb_t         sb_q[$];
  logic [15:0] seq = 16'h0001;
  logic [31:0] last_w_ir = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .IR_E(IR_E), .PC8_E(PC8_E), .ALUOUT_E(ALUOUT_E), .RT_E(RT_E),
    .Forward_RT_M(Forward_RT_M), .mux_Wdata_out(mux_Wdata_out),
    .IR_M(IR_M), .PC8_M(PC8_M), .ALUOUT_M(ALUOUT_M), .RT_M(RT_M),
    .IR_W(IR_W), .PC8_W(PC8_W), .ALUOUT_W(ALUOUT_W), .DM_W(DM_W),
    .adel_M(adel_M), .ades_M(ades_M)
  );

  always #5 clk = ~clk;

  // Present one instruction in E, advance one edge, and retire the one that
  // has now reached W against its scoreboard entry.
  task automatic step(input logic [5:0] op, input logic [31:0] addr,
                      input logic [31:0] rt, input logic fwd,
                      input logic [31:0] fdata, input bit chk,
                      input logic [31:0] exp_dm);
    sb_t e;
    sb_t got;
    @(negedge clk);
    e.ir  = {op, 10'd0, seq};
    e.pc8 = 32'h0040_0000 + {14'd0, seq, 2'b00};
    e.alu = addr;
    e.chk = chk;
    e.dm  = exp_dm;
    IR_E = e.ir; PC8_E = e.pc8; ALUOUT_E = addr; RT_E = rt;
    Forward_RT_M = fwd; mux_Wdata_out = fdata; en = 1'b1;
    sb_q.push_back(e);
    seq = seq + 16'd1;
    @(posedge clk); #1;
    if (sb_q.size() == 2) begin
      got = sb_q.pop_front();
      last_w_ir = got.ir;
      n_checks++;
      if (IR_W !== got.ir || PC8_W !== got.pc8 || ALUOUT_W !== got.alu) begin
        n_fail++;
        $display("[TB] FAIL w_regs: actual ir=%h pc8=%h alu=%h required ir=%h pc8=%h alu=%h",
                 IR_W, PC8_W, ALUOUT_W, got.ir, got.pc8, got.alu);
      end
      if (got.chk) begin
        n_checks++;
        if (DM_W !== got.dm) begin
          n_fail++;
          $display("[TB] FAIL dm_w (ir %h): actual %h required %h", got.ir, DM_W, got.dm);
        end
      end
    end
  endtask

  // Outputs clear immediately under reset; then the pipe latency is two edges.
  task automatic test_reset();
    logic [31:0] outs [8];
    rst_n = 1'b0; en = 1'b1;
    IR_E = 32'h8C00_0010; PC8_E = 32'h0040_0008; ALUOUT_E = 32'h10;
    RT_E = 32'hFFFF_FFFF; Forward_RT_M = 1'b1; mux_Wdata_out = 32'h1234_5678;
    #2;
    outs = '{IR_M, PC8_M, ALUOUT_M, RT_M, IR_W, PC8_W, ALUOUT_W, DM_W};
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (outs[i] !== 32'h0) begin
        n_fail++;
        $display("[TB] FAIL reset_out%0d: actual %h required 00000000", i, outs[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(OP_ORI, 32'h0000_0010, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    step(OP_NOP, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
  endtask

  // Full-word store followed directly by a load of the same word.
  task automatic test_word();
    step(OP_SW, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 32'h0);
    step(OP_LW, 32'h10, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
  endtask

  // Byte and halfword stores into a zero word, then every load flavour.
  task automatic test_subword();
    step(OP_SB,  32'h21, 32'h0000_0080, 1'b0, 32'h0, 1'b0, 32'h0);
    step(OP_SH,  32'h22, 32'hFFFF_1234, 1'b0, 32'h0, 1'b0, 32'h0);
    step(OP_LW,  32'h20, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1234_8000);
    step(OP_LB,  32'h21, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FF80);
    step(OP_LBU, 32'h21, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0080);
    step(OP_LH,  32'h22, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_1234);
    step(OP_LH,  32'h20, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_8000);
    step(OP_LHU, 32'h20, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_8000);
  endtask

  // Misaligned load yields 0 and flags; misaligned store flags and is dropped.
  task automatic test_misalign();
    step(OP_LW, 32'h13, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    n_checks++;
    if (adel_M !== 1'b1 || ades_M !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL adel_lw13: actual adel=%b ades=%b required adel=1 ades=0", adel_M, ades_M);
    end
    step(OP_SH, 32'h15, 32'h0000_BEEF, 1'b0, 32'h0, 1'b0, 32'h0);
    n_checks++;
    if (ades_M !== 1'b1 || adel_M !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ades_sh15: actual ades=%b adel=%b required ades=1 adel=0", ades_M, adel_M);
    end
    step(OP_LW, 32'h14, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    n_checks++;
    if (adel_M !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL adel_lw14: actual %b required 0", adel_M);
    end
  endtask

  // Store data taken from write-back when forwarding is selected.
  task automatic test_forward();
    step(OP_SW, 32'h30, 32'h0000_0001, 1'b0, 32'h0, 1'b0, 32'h0);
    step(OP_LW, 32'h30, 32'h0, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5);
    step(OP_SW, 32'h34, 32'h0000_1234, 1'b0, 32'h0, 1'b0, 32'h0);
    step(OP_LW, 32'h34, 32'h0, 1'b0, 32'h5A5A_5A5A, 1'b1, 32'h0000_1234);
  endtask

  // Frozen registers while en is low; reset during a stall drops the store;
  // a stalled store commits the forwarded data present at the releasing edge.
  task automatic test_stall();
    logic [31:0] frz_ir_m;
    logic [31:0] frz_ir_w;
    step(OP_SW, 32'h40, 32'h5555_AAAA, 1'b0, 32'h0, 1'b0, 32'h0);
    frz_ir_m = sb_q[sb_q.size()-1].ir;
    frz_ir_w = last_w_ir;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      en = 1'b0; IR_E = $urandom; ALUOUT_E = $urandom; RT_E = $urandom;
      Forward_RT_M = 1'b1; mux_Wdata_out = 32'h1111_1111;
      @(posedge clk); #1;
      n_checks++;
      if (IR_M !== frz_ir_m || IR_W !== frz_ir_w || RT_M !== 32'h5555_AAAA
          || ALUOUT_M !== 32'h40) begin
        n_fail++;
        $display("[TB] FAIL stall_hold%0d: actual ir_m=%h ir_w=%h rt_m=%h alu_m=%h required ir_m=%h ir_w=%h rt_m=5555aaaa alu_m=00000040",
                 c, IR_M, IR_W, RT_M, ALUOUT_M, frz_ir_m, frz_ir_w);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (IR_M !== 32'h0 || IR_W !== 32'h0 || DM_W !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: actual ir_m=%h ir_w=%h dm_w=%h required all 00000000",
               IR_M, IR_W, DM_W);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    step(OP_SW, 32'h44, 32'h0000_0001, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      en = 1'b0; Forward_RT_M = 1'b1; mux_Wdata_out = 32'h1111_1111;
      @(posedge clk); #1;
    end
    step(OP_LW, 32'h40, 32'h0, 1'b1, 32'h2222_2222, 1'b1, 32'h0);
    step(OP_LW, 32'h44, 32'h0, 1'b0, 32'h0, 1'b1, 32'h2222_2222);
  endtask

  // Range edge: last valid word works, first address past the end is refused.
  task automatic test_range();
    step(OP_SW, 32'h1000, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 32'h0);
    n_checks++;
    if (ades_M !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ades_range: actual %b required 1", ades_M);
    end
    step(OP_LW, 32'h1000, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    n_checks++;
    if (adel_M !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL adel_range: actual %b required 1", adel_M);
    end
    step(OP_LW, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    step(OP_SW, 32'hFFC, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 32'h0);
    n_checks++;
    if (ades_M !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ades_last_word: actual %b required 0", ades_M);
    end
    step(OP_LW, 32'hFFC, 32'h0, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D);
  endtask

  // Dense mix of stores and loads with no bubbles between them.
  task automatic test_back_to_back();
    step(OP_SW,  32'h50, 32'h0A0B_0C0D, 1'b0, 32'h0, 1'b0, 32'h0);
    step(OP_SW,  32'h54, 32'h0102_0304, 1'b0, 32'h0, 1'b0, 32'h0);
    step(OP_LW,  32'h50, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0A0B_0C0D);
    step(OP_SB,  32'h57, 32'h0000_00EE, 1'b0, 32'h0, 1'b0, 32'h0);
    step(OP_LW,  32'h54, 32'h0, 1'b0, 32'h0, 1'b1, 32'hEE02_0304);
    step(OP_LB,  32'h57, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFEE);
    step(OP_SH,  32'h50, 32'h0000_9876, 1'b0, 32'h0, 1'b0, 32'h0);
    step(OP_LHU, 32'h50, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_9876);
    step(OP_LW,  32'h50, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0A0B_9876);
    step(OP_NOP, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    step(OP_NOP, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_word();
    test_subword();
    test_misalign();
    test_forward();
    test_stall();
    test_range();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
